// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: word-organised data memory with B/H/W loads and stores,
// sign/zero extension, configurable wait states and a one-cycle ready pulse.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned H/W accesses complete
// with err instead of being silently aligned).
module data_memory_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    input  logic [2:0]        funct3,
    input  logic              MemWrite,
    input  logic              MemRead,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic              err
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW    = IDX_W + 2;   // byte address bits that actually select storage

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    f3_q, f3_d;
    logic          store_q, store_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;

    logic [31:0]      mem [DEPTH];
    logic [AW-1:0]    eff_addr;
    logic [IDX_W-1:0] idx;
    logic [4:0]       shamt;
    logic [3:0]       be;
    logic [31:0]      rword, lsb, wshift, wmerge, load_val;
    logic             legal, misaligned, reject, mem_we;

    // Address bits above the array index wrap, so they are deliberately dropped.
    generate
        if (ADDR_W > AW) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^address[ADDR_W-1:AW];
        end
    endgenerate

    // Decode the latched request: legality, alignment, lanes, merged store word, extended load.
    always_comb begin
        eff_addr   = addr_q;
        misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
        misaligned = (f3_q[1:0] == 2'b01 && addr_q[0]) ||
                     (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`else
        if (f3_q[1:0] == 2'b01)
            eff_addr[0] = 1'b0;
        else if (f3_q[1:0] == 2'b10)
            eff_addr[1:0] = 2'b00;
`endif
        if (store_q)
            legal = f3_q inside {3'b000, 3'b001, 3'b010};
        else
            legal = f3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        reject = !legal || misaligned;

        idx   = eff_addr[AW-1:2];
        shamt = {eff_addr[1:0], 3'b000};
        rword = mem[idx];
        lsb   = rword >> shamt;

        case (f3_q[1:0])
            2'b00:   be = 4'b0001 << eff_addr[1:0];
            2'b01:   be = 4'b0011 << eff_addr[1:0];
            default: be = 4'b1111;
        endcase

        // Store data is right-aligned; shift it into its lane and keep untouched bytes.
        wshift = wdata_q << shamt;
        for (int i = 0; i < 4; i++)
            wmerge[8*i +: 8] = be[i] ? wshift[8*i +: 8] : rword[8*i +: 8];

        // funct3[2] selects zero extension for B/H.
        case (f3_q[1:0])
            2'b00:   load_val = {{24{~f3_q[2] & lsb[7]}},  lsb[7:0]};
            2'b01:   load_val = {{16{~f3_q[2] & lsb[15]}}, lsb[15:0]};
            default: load_val = lsb;
        endcase
    end

    // Next-state logic for IDLE -> BUSY -> DONE handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        f3_d        = f3_q;
        store_d     = store_q;
        read_data_d = read_data_q;
        ready_d     = 1'b0;
        err_d       = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    addr_d  = address[AW-1:0];
                    wdata_d = write_data;
                    f3_d    = funct3;
                    store_d = MemWrite;           // store wins when both are asserted
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    if (reject)
                        err_d = 1'b1;
                    else if (store_q)
                        mem_we = 1'b1;
                    else
                        read_data_d = load_val;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;              // DONE: requests are ignored here
        endcase
    end

    // Control and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            f3_q        <= 3'd0;
            store_q     <= 1'b0;
            read_data_q <= 32'd0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            store_q     <= store_d;
            read_data_q <= read_data_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    // Storage array is not reset; writes only at the commit edge of a legal store.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[idx] <= wmerge;
    end

    assign read_data = read_data_q;
    assign ready     = ready_q;
    assign err       = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (WAIT_STATES 0 and 3) driven in turn,
// expected results queued on a scoreboard and compared when ready pulses.
module tb_data_memory_ctrl;
    localparam int WS0 = 0;
    localparam int WS1 = 3;

    logic        clk = 1'b0;
    logic        rst_n      [2];
    logic [31:0] address    [2];
    logic [31:0] write_data [2];
    logic [2:0]  funct3     [2];
    logic        MemWrite   [2];
    logic        MemRead    [2];
    logic [31:0] read_data  [2];
    logic        ready      [2];
    logic        err        [2];

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] last_rd [2];

    typedef struct { logic [31:0] rd; logic er; } exp_t;
    typedef struct {
        bit wr; logic [31:0] a; logic [31:0] d; logic [2:0] f3;
        bit hold; logic [31:0] rd; bit er;
    } req_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    data_memory_ctrl #(.ADDR_W(32), .DEPTH(256), .WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .address(address[0]), .write_data(write_data[0]),
        .funct3(funct3[0]), .MemWrite(MemWrite[0]), .MemRead(MemRead[0]),
        .read_data(read_data[0]), .ready(ready[0]), .err(err[0]));

    data_memory_ctrl #(.ADDR_W(32), .DEPTH(256), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .address(address[1]), .write_data(write_data[1]),
        .funct3(funct3[1]), .MemWrite(MemWrite[1]), .MemRead(MemRead[1]),
        .read_data(read_data[1]), .ready(ready[1]), .err(err[1]));

    function automatic int ws(input int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    function automatic req_t mk(input bit wr, input logic [31:0] a, input logic [31:0] dat,
                                input logic [2:0] f3, input bit hold,
                                input logic [31:0] rd, input bit er);
        req_t r;
        r.wr = wr; r.a = a; r.d = dat; r.f3 = f3; r.hold = hold; r.rd = rd; r.er = er;
        return r;
    endfunction

    // Drive one request, return outputs at the ready pulse, edges to ready, and ready one cycle later.
    task automatic access(input int d, input req_t r, output logic [31:0] rd, output logic er,
                          output int lat, output logic rdy_after);
        @(negedge clk);
        address[d] = r.a; write_data[d] = r.d; funct3[d] = r.f3;
        MemWrite[d] = r.wr; MemRead[d] = !r.wr;
        @(posedge clk);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            MemWrite[d] = 1'b0; MemRead[d] = 1'b0;
            if (ready[d] === 1'b1) break;
            @(posedge clk);
            lat++;
        end
        rd = read_data[d]; er = err[d];
        @(negedge clk);
        rdy_after = ready[d];
    endtask

    task automatic test_reset(input int d);
        n_checks++;
        if ({read_data[d], ready[d], err[d]} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_state dut%0d: read_data=%h ready=%b err=%b, want 0 0 0",
                     d, read_data[d], ready[d], err[d]);
        end
    endtask

    task automatic test_word(input int d);
        req_t t[$]; exp_t e; logic [31:0] rd; logic er; logic ra; int lat;
        t.push_back(mk(1, 32'h28, 32'h1, 3'b010, 1, 32'h0, 0));
        t.push_back(mk(0, 32'h28, 32'h0, 3'b010, 0, 32'h1, 0));
        foreach (t[i]) begin
            sb.push_back('{t[i].hold ? last_rd[d] : t[i].rd, t[i].er});
            access(d, t[i], rd, er, lat, ra);
            e = sb.pop_front();
            n_checks++;
            if ({rd, er} !== {e.rd, e.er}) begin
                n_fail++;
                $display("FAIL word[%0d] dut%0d: read_data=%h err=%b, want %h %b", i, d, rd, er, e.rd, e.er);
            end
            n_checks++;
            if (lat !== ws(d) + 1 || ra !== 1'b0) begin
                n_fail++;
                $display("FAIL word_latency[%0d] dut%0d: lat=%0d ready_after=%b, want %0d 0", i, d, lat, ra, ws(d) + 1);
            end
            last_rd[d] = e.rd;
        end
    endtask

    task automatic test_subword(input int d);
        req_t t[$]; exp_t e; logic [31:0] rd; logic er; logic ra; int lat;
        t.push_back(mk(1, 32'h28, 32'h11223344, 3'b010, 1, 32'h0, 0));
        t.push_back(mk(1, 32'h29, 32'h000000AB, 3'b000, 1, 32'h0, 0));
        t.push_back(mk(0, 32'h28, 32'h0, 3'b010, 0, 32'h1122AB44, 0));
        t.push_back(mk(0, 32'h29, 32'h0, 3'b000, 0, 32'hFFFFFFAB, 0));
        t.push_back(mk(0, 32'h29, 32'h0, 3'b100, 0, 32'h000000AB, 0));
        t.push_back(mk(1, 32'h2A, 32'h00008001, 3'b001, 1, 32'h0, 0));
        t.push_back(mk(0, 32'h2A, 32'h0, 3'b001, 0, 32'hFFFF8001, 0));
        t.push_back(mk(0, 32'h2A, 32'h0, 3'b101, 0, 32'h00008001, 0));
        t.push_back(mk(0, 32'h28, 32'h0, 3'b010, 0, 32'h8001AB44, 0));
        foreach (t[i]) begin
            sb.push_back('{t[i].hold ? last_rd[d] : t[i].rd, t[i].er});
            access(d, t[i], rd, er, lat, ra);
            e = sb.pop_front();
            n_checks++;
            if ({rd, er} !== {e.rd, e.er}) begin
                n_fail++;
                $display("FAIL subword[%0d] dut%0d: read_data=%h err=%b, want %h %b", i, d, rd, er, e.rd, e.er);
            end
            n_checks++;
            if (lat !== ws(d) + 1 || ra !== 1'b0) begin
                n_fail++;
                $display("FAIL subword_latency[%0d] dut%0d: lat=%0d ready_after=%b, want %0d 0", i, d, lat, ra, ws(d) + 1);
            end
            last_rd[d] = e.rd;
        end
    endtask

    task automatic test_misalign(input int d);
        req_t t[$]; exp_t e; logic [31:0] rd; logic er; logic ra; int lat;
`ifdef MISALIGN_TRAP_EN
        t.push_back(mk(0, 32'h2A, 32'h0, 3'b010, 1, 32'h0, 1));
        t.push_back(mk(0, 32'h2B, 32'h0, 3'b001, 1, 32'h0, 1));
        t.push_back(mk(1, 32'h2A, 32'hFFFFFFFF, 3'b010, 1, 32'h0, 1));
        t.push_back(mk(0, 32'h28, 32'h0, 3'b010, 0, 32'h8001AB44, 0));
`else
        t.push_back(mk(0, 32'h2A, 32'h0, 3'b010, 0, 32'h8001AB44, 0));
        t.push_back(mk(0, 32'h2B, 32'h0, 3'b001, 0, 32'hFFFF8001, 0));
        t.push_back(mk(1, 32'h2A, 32'hFFFFFFFF, 3'b010, 1, 32'h0, 0));
        t.push_back(mk(0, 32'h28, 32'h0, 3'b010, 0, 32'hFFFFFFFF, 0));
`endif
        foreach (t[i]) begin
            sb.push_back('{t[i].hold ? last_rd[d] : t[i].rd, t[i].er});
            access(d, t[i], rd, er, lat, ra);
            e = sb.pop_front();
            n_checks++;
            if ({rd, er} !== {e.rd, e.er}) begin
                n_fail++;
                $display("FAIL misalign[%0d] dut%0d: read_data=%h err=%b, want %h %b", i, d, rd, er, e.rd, e.er);
            end
            last_rd[d] = e.rd;
        end
    endtask

    task automatic test_illegal(input int d);
        req_t t[$]; exp_t e; logic [31:0] rd; logic er; logic ra; int lat;
        t.push_back(mk(1, 32'h28, 32'h01020304, 3'b010, 1, 32'h0, 0));
        t.push_back(mk(0, 32'h28, 32'h0, 3'b000, 0, 32'h00000004, 0));
        t.push_back(mk(1, 32'h28, 32'h0, 3'b100, 1, 32'h0, 1));
        t.push_back(mk(1, 32'h28, 32'h0, 3'b011, 1, 32'h0, 1));
        t.push_back(mk(0, 32'h28, 32'h0, 3'b111, 1, 32'h0, 1));
        t.push_back(mk(0, 32'h28, 32'h0, 3'b110, 1, 32'h0, 1));
        t.push_back(mk(0, 32'h28, 32'h0, 3'b010, 0, 32'h01020304, 0));
        foreach (t[i]) begin
            sb.push_back('{t[i].hold ? last_rd[d] : t[i].rd, t[i].er});
            access(d, t[i], rd, er, lat, ra);
            e = sb.pop_front();
            n_checks++;
            if ({rd, er} !== {e.rd, e.er} || lat !== ws(d) + 1) begin
                n_fail++;
                $display("FAIL illegal[%0d] dut%0d: read_data=%h err=%b lat=%0d, want %h %b %0d",
                         i, d, rd, er, lat, e.rd, e.er, ws(d) + 1);
            end
            last_rd[d] = e.rd;
        end
    endtask

    // Hold MemRead high: second access is re-accepted after DONE, WAIT_STATES+3 apart.
    task automatic test_back_to_back(input int d);
        int k; int pulses; int at[2]; exp_t e;
        sb.push_back('{32'h01020304, 1'b0});
        sb.push_back('{32'h01020304, 1'b0});
        @(negedge clk);
        address[d] = 32'h28; funct3[d] = 3'b010; MemRead[d] = 1'b1; MemWrite[d] = 1'b0;
        @(posedge clk);
        k = 0; pulses = 0; at[0] = -1; at[1] = -1;
        while (k < 40 && pulses < 2) begin
            @(negedge clk);
            if (ready[d] === 1'b1) begin
                at[pulses] = k;
                e = sb.pop_front();
                n_checks++;
                if ({read_data[d], err[d]} !== {e.rd, e.er}) begin
                    n_fail++;
                    $display("FAIL b2b_data[%0d] dut%0d: read_data=%h err=%b, want %h %b",
                             pulses, d, read_data[d], err[d], e.rd, e.er);
                end
                pulses++;
                if (pulses == 2) MemRead[d] = 1'b0;
            end
            if (pulses < 2) begin
                @(posedge clk);
                k++;
            end
        end
        MemRead[d] = 1'b0;
        n_checks++;
        if (at[0] !== ws(d) + 1 || at[1] !== 2 * ws(d) + 4) begin
            n_fail++;
            $display("FAIL b2b_timing dut%0d: pulses at %0d,%0d, want %0d,%0d",
                     d, at[0], at[1], ws(d) + 1, 2 * ws(d) + 4);
        end
        sb.delete();
        last_rd[d] = 32'h01020304;
        @(negedge clk);
    endtask

    // Asynchronous reset in the middle of a load clears the outputs before the next edge.
    task automatic test_async_reset(input int d);
        logic [31:0] rd; logic er; logic ra; int lat;
        access(d, mk(1, 32'h40, 32'h12345678, 3'b010, 1, 32'h0, 0), rd, er, lat, ra);
        access(d, mk(0, 32'h40, 32'h0, 3'b010, 0, 32'h0, 0), rd, er, lat, ra);
        n_checks++;
        if (rd !== 32'h12345678) begin
            n_fail++;
            $display("FAIL pre_reset_load dut%0d: read_data=%h, want 12345678", d, rd);
        end
        @(negedge clk);
        address[d] = 32'h44; funct3[d] = 3'b010; MemRead[d] = 1'b1;
        @(posedge clk);
        #3 rst_n[d] = 1'b0;
        MemRead[d] = 1'b0;
        #1;
        n_checks++;
        if ({read_data[d], ready[d], err[d]} !== 34'd0) begin
            n_fail++;
            $display("FAIL async_reset dut%0d: read_data=%h ready=%b err=%b, want 0 0 0",
                     d, read_data[d], ready[d], err[d]);
        end
        last_rd[d] = 32'h0;
        repeat (2) @(negedge clk);
        rst_n[d] = 1'b1;
        access(d, mk(0, 32'h40, 32'h0, 3'b010, 0, 32'h0, 0), rd, er, lat, ra);
        n_checks++;
        if (rd !== 32'h12345678 || lat !== ws(d) + 1) begin
            n_fail++;
            $display("FAIL post_reset_load dut%0d: read_data=%h lat=%0d, want 12345678 %0d", d, rd, lat, ws(d) + 1);
        end
        last_rd[d] = 32'h12345678;
    endtask

    // A store cut off by reset before its commit edge must leave the array untouched.
    task automatic test_reset_abort(input int d);
        logic [31:0] rd; logic er; logic ra; int lat;
        access(d, mk(1, 32'h30, 32'h0BADF00D, 3'b010, 1, 32'h0, 0), rd, er, lat, ra);
        @(negedge clk);
        address[d] = 32'h30; write_data[d] = 32'hDEADBEEF; funct3[d] = 3'b010; MemWrite[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        MemWrite[d] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n[d] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n[d] = 1'b1;
        last_rd[d] = 32'h0;
        access(d, mk(0, 32'h30, 32'h0, 3'b010, 0, 32'h0, 0), rd, er, lat, ra);
        n_checks++;
        if (rd !== 32'h0BADF00D || er !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort dut%0d: read_data=%h err=%b, want 0badf00d 0", d, rd, er);
        end
        last_rd[d] = rd;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; address[d] = 32'h0; write_data[d] = 32'h0; funct3[d] = 3'b0;
            MemWrite[d] = 1'b0; MemRead[d] = 1'b0; last_rd[d] = 32'h0;
        end
        #1;
        test_reset(0);
        test_reset(1);
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        for (int d = 0; d < 2; d++) begin
            test_word(d);
            test_subword(d);
            test_misalign(d);
            test_illegal(d);
            test_back_to_back(d);
            test_async_reset(d);
        end
        test_reset_abort(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
